rv32i_dmem_resp: RTL and testbench

Data-memory responder for the rv32i core's load/store port. It sits on the other end of write / data_addr / data_out / data_in.
- Accepts one request at a time and inserts a programmable number of wait states.
- Performs byte, halfword and word writes via byte lanes.
- Returns load data right-aligned; the core does its own sign/zero extension.
- Flags misaligned, out-of-range and illegal-size accesses.

---
 rtl/rv32i_pkg.sv | 39 +++
 rtl/dmem_lane_align.sv | 82 ++++++++
 rtl/rv32i_dmem_resp.sv | 171 +++++++++++++++++
 tb/tb_rv32i_dmem_resp.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the rv32i core and its memory-side blocks.
//   - SZ_*     : func3 access-size codes used on the load/store port
//   - OP_*     : load/store major opcodes, identical to the core's decode
//   - state_t  : handshake states of the data-memory responder
//   - size_legal() : true for the five func3 codes a load/store may carry
// ----------------------------------------------------------------------------
package rv32i_pkg;

    // func3 encodings of the load/store access size
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // Major opcodes of the load and store instruction groups
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Responder handshake states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // 011, 110 and 111 have no meaning as a memory access size
    function automatic logic size_legal(input logic [2:0] size);
        logic ok;
        case (size)
            SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// ----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane steering between the core's right-aligned
// data and the 32-bit memory word.
//
// Ports:
//   addr       in   2  low byte-address bits of the access
//   size       in   3  func3 access size
//   wdata      in  32  store data from the core, right-aligned
//   rword      in  32  word currently held in the addressed array row
//   be         out  4  byte write enables, bit i = byte lane i
//   wdata_lane out 32  store data replicated onto every lane it may hit
//   rdata      out 32  selected bytes of rword, right-aligned, zero-filled
//   misalign   out  1  halfword on an odd address or word off a 4-byte boundary
//
// Illegal size codes produce an all-zero mask and zero read data; the
// parent flags them separately.
// ----------------------------------------------------------------------------
module dmem_lane_align
    import rv32i_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword out of the stored word
    always_comb begin
        byte_sel = rword[7:0];
        case (addr)
            2'd0:    byte_sel = rword[7:0];
            2'd1:    byte_sel = rword[15:8];
            2'd2:    byte_sel = rword[23:16];
            default: byte_sel = rword[31:24];
        endcase
        half_sel = addr[1] ? rword[31:16] : rword[15:0];
    end

    // Store data is replicated across lanes so the byte mask alone decides
    // which lanes change; upper store bits beyond the access size are never
    // routed to a lane, so a sign-filled data_out is harmless.
    always_comb begin
        be         = 4'b0000;
        wdata_lane = 32'h0;
        rdata      = 32'h0;
        misalign   = 1'b0;
        case (size)
            SZ_B, SZ_BU: begin
                be         = 4'b0001 << addr;
                wdata_lane = {4{wdata[7:0]}};
                rdata      = {24'h0, byte_sel};
            end
            SZ_H, SZ_HU: begin
                misalign   = addr[0];
                be         = addr[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata      = {16'h0, half_sel};
            end
            SZ_W: begin
                misalign   = (addr != 2'd0);
                be         = 4'b1111;
                wdata_lane = wdata;
                rdata      = rword;
            end
            default: begin
                be         = 4'b0000;
                wdata_lane = 32'h0;
                rdata      = 32'h0;
                misalign   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rv32i_dmem_resp.sv
// ----------------------------------------------------------------------------
// rv32i_dmem_resp
// Data-memory responder for the rv32i load/store port. Accepts one request
// at a time, waits WAIT cycles, then commits the access to a DEPTH x 32-bit
// array and pulses ack for one cycle with err and right-aligned load data.
//
// Parameters:
//   DEPTH  number of 32-bit words (byte space is 4*DEPTH)
//   WAIT   wait states between accept and ack, 0..15
//   AW     width of data_addr
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   req        in   1  access request, only looked at in IDLE
//   write      in   1  1 = store, 0 = load
//   size       in   3  func3 access size
//   data_addr  in  AW  byte address
//   data_out   in  32  store data, right-aligned
//   data_in    out 32  load data, right-aligned, zero for stores and errors
//   ack        out  1  one-cycle completion strobe
//   err        out  1  access rejected, valid with ack
//   busy       out  1  high while in BUSY or RESP
//
// The request is captured whole at accept, so the core may change its
// outputs while the access is in flight. Array write and read sampling both
// happen on the BUSY->RESP edge (the commit edge); a reset before that edge
// drops the access without touching the array and without an ack.
// ----------------------------------------------------------------------------
module rv32i_dmem_resp
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WAIT  = 1,
    parameter int AW    = 32
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          write,
    input  logic [2:0]    size,
    input  logic [AW-1:0] data_addr,
    input  logic [31:0]   data_out,
    output logic [31:0]   data_in,
    output logic          ack,
    output logic          err,
    output logic          busy
);

    localparam int            IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]    WAIT_CNT  = 4'(WAIT);
    localparam logic [AW-1:0] DEPTH_LIM = AW'(DEPTH);

    state_t        state;
    logic [3:0]    cnt;

    logic          req_write;
    logic [2:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;

    logic [31:0]   mem [DEPTH];

    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rword;
    logic [3:0]       be;
    logic [31:0]      wdata_lane;
    logic [31:0]      rdata;
    logic             misalign;
    logic             size_err;
    logic             range_err;
    logic             acc_err;
    logic             commit;
    logic             do_write;

    // The full word index is compared against DEPTH, not just the bits used
    // to address the array, so addresses beyond the array never wrap around
    // onto real rows.
    always_comb begin
        word_idx  = req_addr[IDX_W+1:2];
        rword     = mem[word_idx];
        size_err  = !size_legal(req_size);
        range_err = ({2'b00, req_addr[AW-1:2]} >= DEPTH_LIM);
        acc_err   = size_err | misalign | range_err;
        commit    = (state == BUSY) && (cnt == 4'd0);
        do_write  = commit && req_write && !acc_err;
    end

    dmem_lane_align u_align (
        .addr       (req_addr[1:0]),
        .size       (req_size),
        .wdata      (req_wdata),
        .rword      (rword),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata      (rdata),
        .misalign   (misalign)
    );

    // Storage array: not reset, written lane by lane only on the commit edge
    // of an error-free store. Reset holds the FSM in IDLE, which keeps
    // commit low, so a dropped access can never reach the array.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
                end
            end
        end
    end

    // Handshake FSM with registered ack/err/busy/data_in. BUSY counts the
    // captured wait states down to zero; the edge that leaves BUSY is the
    // commit edge and loads the response registers. RESP lasts one cycle and
    // ignores req, which gives back-to-back requests one dead IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            ack       <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            data_in   <= 32'h0;
            req_write <= 1'b0;
            req_size  <= 3'b000;
            req_addr  <= '0;
            req_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= 1'b0;
                    err <= 1'b0;
                    if (req) begin
                        req_write <= write;
                        req_size  <= size;
                        req_addr  <= data_addr;
                        req_wdata <= data_out;
                        cnt       <= WAIT_CNT;
                        busy      <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        ack     <= 1'b1;
                        err     <= acc_err;
                        data_in <= (acc_err || req_write) ? 32'h0 : rdata;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_dmem_resp.sv
// ----------------------------------------------------------------------------
// tb_rv32i_dmem_resp
// Three responders share clock, reset and request fields; each has its own
// req and outputs. Instance 0 runs WAIT=1, instance 1 WAIT=3, instance 2
// WAIT=0, all with DEPTH=1024. A byte-addressed reference memory per
// instance supplies every expected load value and error flag.
// ----------------------------------------------------------------------------
module tb_rv32i_dmem_resp;

    localparam int DEPTH = 1024;
    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010,
                           BU = 3'b100, HU = 3'b101, BAD = 3'b011;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_v;
    logic        write;
    logic [2:0]  size;
    logic [31:0] data_addr;
    logic [31:0] data_out;
    logic [31:0] data_in_v [3];
    logic [2:0]  ack_v;
    logic [2:0]  err_v;
    logic [2:0]  busy_v;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [3][4*DEPTH];

    rv32i_dmem_resp #(.DEPTH(DEPTH), .WAIT(1), .AW(32)) u_w1 (
        .clk(clk), .rst_n(rst_n), .req(req_v[0]), .write(write), .size(size),
        .data_addr(data_addr), .data_out(data_out), .data_in(data_in_v[0]),
        .ack(ack_v[0]), .err(err_v[0]), .busy(busy_v[0])
    );

    rv32i_dmem_resp #(.DEPTH(DEPTH), .WAIT(3), .AW(32)) u_w3 (
        .clk(clk), .rst_n(rst_n), .req(req_v[1]), .write(write), .size(size),
        .data_addr(data_addr), .data_out(data_out), .data_in(data_in_v[1]),
        .ack(ack_v[1]), .err(err_v[1]), .busy(busy_v[1])
    );

    rv32i_dmem_resp #(.DEPTH(DEPTH), .WAIT(0), .AW(32)) u_w0 (
        .clk(clk), .rst_n(rst_n), .req(req_v[2]), .write(write), .size(size),
        .data_addr(data_addr), .data_out(data_out), .data_in(data_in_v[2]),
        .ack(ack_v[2]), .err(err_v[2]), .busy(busy_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something outside the bounded loops stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int wait_of(input int d);
        int w;
        case (d)
            0:       w = 1;
            1:       w = 3;
            default: w = 0;
        endcase
        return w;
    endfunction

    // Reference rules: legal size, natural alignment, inside 4*DEPTH bytes
    function automatic logic model_err(input logic [2:0] sz, input logic [31:0] a);
        int unsigned n;
        if (!(sz inside {B, H, W, BU, HU})) return 1'b1;
        n = 1 << sz[1:0];
        if ((a % n) != 0) return 1'b1;
        if ((a / 4) >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_store(input int d, input logic [2:0] sz,
                                        input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 1 << sz[1:0];
        for (int i = 0; i < n; i++) ref_mem[d][int'(a) + i] = wd[8*i +: 8];
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [2:0] sz,
                                               input logic [31:0] a);
        logic [31:0] v;
        int n;
        v = 32'h0;
        n = 1 << sz[1:0];
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[d][int'(a) + i];
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One complete access on instance d: wait for IDLE, present the request
    // for one edge, scramble the request fields, then follow the handshake.
    // Ack must be high in cycle N+WAIT+2, i.e. first seen WAIT+1 edges after
    // the accept edge N, and busy must be seen for WAIT+2 samples.
    task automatic applyStimulus(input int d, input logic wr, input logic [2:0] sz,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input string tag);
        logic [31:0] exp_data;
        logic        exp_e;
        logic        seen;
        int          cyc;
        int          busy_cnt;

        cyc = 0;
        while (busy_v[d] && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end

        exp_e    = model_err(sz, a);
        exp_data = 32'h0;
        if (!exp_e) begin
            if (wr) model_store(d, sz, a, wd);
            else    exp_data = model_load(d, sz, a);
        end

        write     = wr;
        size      = sz;
        data_addr = a;
        data_out  = wd;
        req_v[d]  = 1'b1;
        @(posedge clk); #1;
        req_v[d]  = 1'b0;
        write     = 1'($urandom);
        size      = 3'($urandom);
        data_addr = $urandom;
        data_out  = $urandom;

        busy_cnt = busy_v[d] ? 1 : 0;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (busy_v[d]) busy_cnt++;
            seen = ack_v[d];
        end
        checkOutput({tag, " ack_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            checkOutput({tag, " ack_latency"}, 32'(cyc), 32'(wait_of(d) + 1));
            checkOutput({tag, " err"}, 32'(err_v[d]), 32'(exp_e));
            checkOutput({tag, " data_in"}, data_in_v[d], exp_data);
            @(posedge clk); #1;
            checkOutput({tag, " ack_one_cycle"}, 32'(ack_v[d]), 32'd0);
            checkOutput({tag, " busy_after"}, 32'(busy_v[d]), 32'd0);
            checkOutput({tag, " busy_cycles"}, 32'(busy_cnt), 32'(wait_of(d) + 2));
        end
    endtask

    initial begin
        int          ack_times[$];
        int          ack_seen_cnt;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] a;
        int          r;

        rst_n     = 1'b0;
        req_v     = 3'b000;
        write     = 1'b0;
        size      = 3'b000;
        data_addr = 32'h0;
        data_out  = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("reset ack%0d", d),  32'(ack_v[d]),  32'd0);
            checkOutput($sformatf("reset err%0d", d),  32'(err_v[d]),  32'd0);
            checkOutput($sformatf("reset busy%0d", d), 32'(busy_v[d]), 32'd0);
            checkOutput($sformatf("reset data%0d", d), data_in_v[d],   32'h0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Word store/load and byte-lane merging on the WAIT=1 instance
        applyStimulus(0, 1'b1, W,  32'h10, 32'hDEADBEEF, "stw10");
        applyStimulus(0, 1'b0, W,  32'h10, 32'h0,        "ldw10");
        applyStimulus(0, 1'b1, B,  32'h11, 32'hFFFFFF5A, "stb11");
        applyStimulus(0, 1'b0, W,  32'h10, 32'h0,        "ldw10b");
        applyStimulus(0, 1'b0, BU, 32'h11, 32'h0,        "ldbu11");
        applyStimulus(0, 1'b0, HU, 32'h12, 32'h0,        "ldhu12");
        applyStimulus(0, 1'b0, B,  32'h13, 32'h0,        "ldb13");
        applyStimulus(0, 1'b0, H,  32'h10, 32'h0,        "ldh10");

        // Rejected accesses leave the array untouched
        applyStimulus(0, 1'b0, H,   32'h13,   32'h0,        "ldh13");
        applyStimulus(0, 1'b1, W,   32'h12,   32'h11223344, "stw12");
        applyStimulus(0, 1'b0, W,   32'h10,   32'h0,        "ldw10c");
        applyStimulus(0, 1'b0, W,   32'h1000, 32'h0,        "ldw1000");
        applyStimulus(0, 1'b1, W,   32'h1010, 32'h55555555, "stw_alias");
        applyStimulus(0, 1'b0, BAD, 32'h10,   32'h0,        "size011");
        applyStimulus(0, 1'b0, W,   32'hFFC,  32'h0,        "ldw_last_unwritten_ok");
        applyStimulus(0, 1'b1, W,   32'hFFC,  32'hA5A5_0F0F, "stw_last");
        applyStimulus(0, 1'b0, W,   32'hFFC,  32'h0,         "ldw_last");
        applyStimulus(0, 1'b0, W,   32'h10,   32'h0,         "ldw10d");

        // Request held high: accepts (and so acks) come every WAIT+3 cycles
        write     = 1'b0;
        size      = W;
        data_addr = 32'h10;
        req_v[0]  = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (ack_v[0]) begin
                ack_times.push_back(c);
                checkOutput($sformatf("held data%0d", c), data_in_v[0], model_load(0, W, 32'h10));
            end
        end
        req_v[0] = 1'b0;
        checkOutput("held ack_count", 32'(ack_times.size() >= 3), 32'd1);
        for (int k = 1; k < ack_times.size(); k++) begin
            checkOutput($sformatf("held spacing%0d", k),
                        32'(ack_times[k] - ack_times[k-1]), 32'(wait_of(0) + 3));
        end
        repeat (8) @(posedge clk);
        #1;

        // Reset during BUSY on the WAIT=3 instance drops the store
        applyStimulus(1, 1'b1, W, 32'h20, 32'hCAFEF00D, "w3_prior");
        write     = 1'b1;
        size      = W;
        data_addr = 32'h20;
        data_out  = 32'h12345678;
        req_v[1]  = 1'b1;
        @(posedge clk); #1;
        req_v[1]  = 1'b0;
        checkOutput("w3 busy_accept", 32'(busy_v[1]), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("w3 busy_in_reset", 32'(busy_v[1]), 32'd0);
        ack_seen_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ack_v[1]) ack_seen_cnt++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ack_v[1]) ack_seen_cnt++;
        end
        checkOutput("w3 no_ack_after_reset", 32'(ack_seen_cnt), 32'd0);
        applyStimulus(1, 1'b0, W, 32'h20, 32'h0, "w3_ld20");

        // WAIT=0 instance
        applyStimulus(2, 1'b1, H,  32'h42, 32'hFFFF_BEEF, "w0_sth");
        applyStimulus(2, 1'b1, H,  32'h40, 32'h0000_1234, "w0_sth2");
        applyStimulus(2, 1'b0, W,  32'h40, 32'h0,         "w0_ldw");
        applyStimulus(2, 1'b0, BU, 32'h43, 32'h0,         "w0_ldbu");

        // Randomized traffic on instance 0 over an initialised window
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1'b1, W, 32'h40 + 32'(4*k), $urandom, $sformatf("init%0d", k));
        end
        for (int k = 0; k < 40; k++) begin
            wr = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 7));
            r  = int'($urandom_range(0, 9));
            if (r == 0)      a = 32'h1000 + 32'($urandom_range(0, 3));
            else if (r == 1) a = 32'h8000_0040 + 32'($urandom_range(0, 7));
            else             a = 32'h40 + 32'($urandom_range(0, 31));
            applyStimulus(0, wr, sz, a, $urandom, $sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
